// File: rtl/image_sram_ctrl.sv
// Image-row SRAM controller: loads one row of pixels from an input stream into the
// SRAM, then reads it back in address order onto an output stream.
module image_sram_ctrl #(
   parameter int unsigned ROW_LEN = 16,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              sram_CS,
   output logic              sram_WE,
   output logic              sram_RD,
   output logic              sram_pixels,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dataIn,
   input  logic [7:0]        sram_dataOut
);

   // One extra counter bit so ROW_LEN may equal 2^ADDR_W.
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRdCmd,
      StRdWait,
      StRdData,
      StPresent
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic [7:0]        dout_q, dout_d;
   logic              ovalid_q, ovalid_d;
   logic              done_q, done_d;
   logic              accept;

   assign in_ready    = (state_q == StLoad);
   assign accept      = in_valid & in_ready;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign out_data    = dout_q;
   assign out_valid   = ovalid_q;
   assign sram_CS     = cs_q;
   assign sram_WE     = we_q;
   assign sram_RD     = rd_q;
   assign sram_addr   = addr_q;
   assign sram_dataIn = din_q;
   assign sram_pixels = 1'b0;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Strobes are single-cycle unless reloaded by the current state.
      cs_d     = 1'b0;
      we_d     = 1'b0;
      rd_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      dout_d   = dout_q;
      ovalid_d = ovalid_q;
      done_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               wr_ptr_d = '0;
               state_d  = StLoad;
            end
         end
         StLoad: begin
            if (accept) begin
               cs_d     = 1'b1;
               we_d     = 1'b1;
               addr_d   = wr_ptr_q[ADDR_W-1:0];
               din_d    = in_data;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == LAST) begin
                  rd_ptr_d = '0;
                  state_d  = StRdCmd;
               end
            end
         end
         StRdCmd: begin
            cs_d    = 1'b1;
            rd_d    = 1'b1;
            addr_d  = rd_ptr_q[ADDR_W-1:0];
            state_d = StRdWait;
         end
         StRdWait: begin
            state_d = StRdData;
         end
         StRdData: begin
            // CS is low here, so the SRAM holds the word it just read.
            dout_d   = sram_dataOut;
            ovalid_d = 1'b1;
            state_d  = StPresent;
         end
         StPresent: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               if (rd_ptr_q == LAST) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  state_d  = StRdCmd;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         rd_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         dout_q   <= '0;
         ovalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         dout_q   <= dout_d;
         ovalid_q <= ovalid_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_image_sram_ctrl.sv
// Self-checking bench for image_sram_ctrl with a registered-SRAM model and
// table-driven row load/readback.
module tb_image_sram_ctrl;

   localparam int ROW = 16;
   localparam int AW  = 4;

   logic          Clk, Rst, start;
   logic [7:0]    in_data;
   logic          in_valid, in_ready;
   logic [7:0]    out_data;
   logic          out_valid, out_ready;
   logic          busy, done;
   logic          sram_CS, sram_WE, sram_RD, sram_pixels;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_dataIn;
   logic [7:0]    sram_dataOut;

   image_sram_ctrl #(
      .ROW_LEN(ROW),
      .ADDR_W (AW)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .start       (start),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .sram_CS     (sram_CS),
      .sram_WE     (sram_WE),
      .sram_RD     (sram_RD),
      .sram_pixels (sram_pixels),
      .sram_addr   (sram_addr),
      .sram_dataIn (sram_dataIn),
      .sram_dataOut(sram_dataOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Registered SRAM: output only changes on a CS&RD edge.
   logic [7:0] mem [ROW];
   initial sram_dataOut = 8'h00;
   always @(posedge Clk) begin
      if (sram_CS && sram_WE) mem[sram_addr] <= sram_dataIn;
      if (sram_CS && sram_RD) sram_dataOut <= mem[sram_addr];
   end

   int done_cnt = 0;
   always @(posedge Clk) if (done) done_cnt <= done_cnt + 1;

   typedef struct packed {
      logic [7:0]    din;
      logic [AW-1:0] addr;
      logic [7:0]    dout;
   } vec_t;

   vec_t tbl [2][ROW];
   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic begin_row;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_in_ready", in_ready, 1);
   endtask

   task automatic load_row(input int r, input bit gaps, input int start_at);
      for (int i = 0; i < ROW; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            tick;
            check("gap_we", sram_WE, 0);
            check("gap_cs", sram_CS, 0);
         end
         in_data  = tbl[r][i].din;
         in_valid = 1'b1;
         start    = (i == start_at);
         tick;
         start    = 1'b0;
         check("wr_cs", sram_CS, 1);
         check("wr_we", sram_WE, 1);
         check("wr_rd", sram_RD, 0);
         check("wr_addr", sram_addr, tbl[r][i].addr);
         check("wr_data", sram_dataIn, tbl[r][i].din);
      end
      in_valid = 1'b0;
      check("load_exit_ready", in_ready, 0);
   endtask

   task automatic read_row(input int r, input int stall_idx, input int abort_idx);
      int cyc;
      out_ready = 1'b1;
      for (int i = 0; i < ROW; i++) begin
         cyc = 0;
         if (i > 0) begin
            tick;
            cyc = 1;
         end
         while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
         end
         check("rd_spacing", cyc, (i == 0) ? 3 : 4);
         check("rd_data", out_data, tbl[r][i].dout);
         check("rd_no_done", done, 0);
         if (i == abort_idx) begin
            #3;
            Rst = 1'b1;
            #1;
            check("arst_valid", out_valid, 0);
            check("arst_data", out_data, 0);
            check("arst_busy", busy, 0);
            check("arst_ready", in_ready, 0);
            check("arst_sram", {sram_CS, sram_WE, sram_RD, sram_addr, sram_dataIn}, 0);
            return;
         end
         if (i == stall_idx) begin
            out_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
               start = (j == 2);
               tick;
               start = 1'b0;
               check("hold_valid", out_valid, 1);
               check("hold_data", out_data, tbl[r][i].dout);
               check("hold_no_rd", sram_RD, 0);
            end
            out_ready = 1'b1;
         end
      end
      tick;
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_valid", out_valid, 0);
      tick;
      check("done_pulse", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < ROW; i++) begin
         tbl[0][i] = '{din: 8'h10 + 8'(i), addr: AW'(i), dout: 8'h10 + 8'(i)};
         tbl[1][i] = '{din: 8'hA0 + 8'(i), addr: AW'(i), dout: 8'hA0 + 8'(i)};
      end
      Rst       = 1'b1;
      start     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) tick;
      check("rst_in_ready", in_ready, 0);
      check("rst_out", {out_valid, out_data}, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_sram", {sram_CS, sram_WE, sram_RD, sram_pixels, sram_addr, sram_dataIn}, 0);
      Rst = 1'b0;
      in_valid = 1'b1;
      tick;
      check("idle_no_busy", busy, 0);
      check("idle_no_write", sram_WE, 0);
      in_valid = 1'b0;

      // Back-to-back load, free-running readback.
      begin_row;
      load_row(0, 1'b0, -1);
      read_row(0, -1, -1);
      check("done_count_1", done_cnt, 1);

      // Gapped input with start during LOAD; backpressure and start during PRESENT.
      begin_row;
      load_row(0, 1'b1, 5);
      read_row(0, 3, -1);
      check("done_count_2", done_cnt, 2);
      check("pixels_low", sram_pixels, 0);

      // Reset during readback of pixel 7.
      begin_row;
      load_row(0, 1'b0, -1);
      read_row(0, -1, 7);
      tick;
      Rst = 1'b0;
      tick;
      check("post_rst_idle", busy, 0);
      check("done_count_rst", done_cnt, 2);

      // Fresh row after reset overwrites from address 0.
      begin_row;
      load_row(1, 1'b0, -1);
      read_row(1, -1, -1);
      check("done_count_3", done_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/image_sram_ctrl.md
# image_sram_ctrl

Initiator-side controller for the image-row SRAM used by the CNN front end. It accepts one row of 8-bit pixels on a valid/ready input stream and writes them into the SRAM at consecutive addresses. It then reads the row back in address order and presents it on a valid/ready output stream to the convolution window logic. It drives the SRAM's CS/WE/RD/addr/dataIn pins from registers and samples the SRAM's registered dataOut.

## Interface
Parameters:
- ROW_LEN, 16: pixels per row; legal range 1..2^ADDR_W.
- ADDR_W, 4: SRAM address width.

Ports:
- Clk  input  1  sole clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a row load; sampled only in IDLE.
- in_data  input  8  pixel to write.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts a pixel this cycle.
- out_data  output  8  pixel read back.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer takes out_data.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last pixel of the row is taken.
- sram_CS, sram_WE, sram_RD  output  1 each  SRAM strobes (registered).
- sram_pixels  output  1  constant 0.
- sram_addr  output  ADDR_W  SRAM address (registered).
- sram_dataIn  output  8  SRAM write data (registered).
- sram_dataOut  input  8  SRAM registered read data.

## Operation
- States: IDLE, LOAD, RD_CMD, RD_WAIT, RD_DATA, PRESENT.
- IDLE: in_ready=0. start=1 moves to LOAD and clears wr_ptr.
- LOAD: in_ready=1.
  - Accept (in_valid & in_ready at an edge): registers load CS=1, WE=1, RD=0, addr=wr_ptr, dataIn=in_data, and wr_ptr increments.
  - Edge without accept: CS and WE register to 0.
  - On the ROW_LEN-th accept: go to RD_CMD, rd_ptr=0.
- RD_CMD: at the edge, registers load CS=1, RD=1, WE=0, addr=rd_ptr. Go to RD_WAIT.
- RD_WAIT: the SRAM samples the read at this edge. Registers clear CS and RD. Go to RD_DATA.
- RD_DATA: sram_dataOut is stable because CS=0 holds it. At the edge, out_data<=sram_dataOut and out_valid<=1. Go to PRESENT.
- PRESENT: out_data/out_valid hold until out_ready=1 at an edge. Then out_valid<=0, and:
  - if rd_ptr==ROW_LEN-1: go to IDLE and assert done for one cycle;
  - else: rd_ptr increments and state goes to RD_CMD.
- WE and RD are never high together. CS is low in IDLE, RD_DATA and PRESENT.
- Counters are ADDR_W+1 bits wide to allow ROW_LEN=2^ADDR_W. sram_addr is the low ADDR_W bits.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, all sram_* outputs=0, pointers=0.
- Write path: pixel accepted at edge k → SRAM strobes asserted during cycle k..k+1 → SRAM writes at edge k+1.
  - Back-to-back accepts give one write per cycle.
- Final write: the ROW_LEN-th accept at edge k also enters RD_CMD. The first read strobe is registered at edge k+1, while the last write completes at that same edge.
- Read path: RD_CMD→PRESENT takes 3 edges, so out_valid rises 3 edges after entering RD_CMD.
  - Minimum 4 cycles per output pixel with out_ready held high.
- start while busy=1 is ignored. start and Rst are never queued.
- in_valid outside LOAD is ignored and not accepted.
- Rst mid-operation: immediate return to reset values; a partial row is discarded. SRAM contents are not cleared, and the next row overwrites from address 0.
- done and out_valid are never high in the same cycle.

## Test plan
- Reset: assert Rst mid-cycle → all outputs 0 asynchronously, state IDLE; start=1 after release → busy=1, in_ready=1 next cycle.
- Load and readback (ROW_LEN=16): feed 0x10..0x1F back-to-back, out_ready=1 → 16 SRAM writes at addr 0..15 with matching dataIn; out_data sequence 0x10..0x1F, each 4 cycles apart; done pulses once; busy falls in the same cycle.
- Input gaps: in_valid toggling 1/0 → sram_WE high only in cycles following accepts; readback still 0x10..0x1F in order.
- Backpressure: out_ready=0 for 5 cycles on pixel 3 → out_data holds 0x13 and out_valid stays high; no sram_RD strobe until release; remaining order intact.
- start during LOAD and PRESENT → no effect on pointers or state; exactly one done per row.
- Reset during readback at pixel 7 → out_valid=0 and IDLE; a new row 0xA0..0xAF loaded after reset reads back 0xA0..0xAF.
